// File: rtl/decode_queue_if.sv
// decode_queue_if
//    Bundles the fetch-side push handshake, the issue-side pop handshake, the
//    flush request, the decoded control fields of the head entry and the
//    occupancy count into one connection.
//    Parameter:
//       DEPTH      - queue entries; sets the width of count
//    Modports:
//       slave      - the queue itself (accepts pushes, offers pops)
//       master     - the surrounding pipeline (pushes, pops, flushes)
//    Signals:
//       flush                             - discard all queued entries
//       in_valid/in_ready/in_instr/in_pc  - push handshake and payload
//       out_valid/out_ready/out_instr/out_pc - pop handshake and head payload
//       reg_write, mem_read, mem_write, branch, jump, alu_src, illegal,
//       alu_op[4:0], wb_sel[1:0], pc_sel[1:0] - decode of the head entry
//       count                             - current occupancy
interface decode_queue_if #(
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [31:0]      in_pc;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_instr;
   logic [31:0]      out_pc;
   logic             reg_write;
   logic             mem_read;
   logic             mem_write;
   logic             branch;
   logic             jump;
   logic             alu_src;
   logic             illegal;
   logic [4:0]       alu_op;
   logic [1:0]       wb_sel;
   logic [1:0]       pc_sel;
   logic [CNT_W-1:0] count;

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_instr, out_pc,
             reg_write, mem_read, mem_write, branch, jump, alu_src, illegal,
             alu_op, wb_sel, pc_sel, count
   );

   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_instr, out_pc,
             reg_write, mem_read, mem_write, branch, jump, alu_src, illegal,
             alu_op, wb_sel, pc_sel, count
   );
endinterface

// File: rtl/decode_queue.sv
// decode_queue
//    Small circular instruction queue between fetch and issue. Entries are
//    pushed with their PC, become visible one cycle later, and the head entry
//    is decoded combinationally into RV32I(+M, +CSR) control fields.
//    Parameters:
//       DEPTH      - queue entries, power of two, >= 2
//       ENABLE_M   - 1: decode RV32M ops, 0: treat them as illegal
//       ENABLE_CSR - 1: SYSTEM funct3!=0 writes back, 0: illegal
//    Ports:
//       clk        - rising-edge clock
//       rst        - synchronous active-high reset
//       q          - decode_queue_if.slave bundle (handshakes, decode, count)
module decode_queue #(
   parameter int DEPTH      = 4,
   parameter int ENABLE_M   = 1,
   parameter int ENABLE_CSR = 1
) (
   input  logic          clk,
   input  logic          rst,
   decode_queue_if.slave q
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [4:0] ALU_ADD    = 5'd0;
   localparam logic [4:0] ALU_SUB    = 5'd1;
   localparam logic [4:0] ALU_AND    = 5'd2;
   localparam logic [4:0] ALU_OR     = 5'd3;
   localparam logic [4:0] ALU_XOR    = 5'd4;
   localparam logic [4:0] ALU_SLL    = 5'd5;
   localparam logic [4:0] ALU_SRL    = 5'd6;
   localparam logic [4:0] ALU_SRA    = 5'd7;
   localparam logic [4:0] ALU_SLT    = 5'd8;
   localparam logic [4:0] ALU_SLTU   = 5'd9;
   localparam logic [4:0] ALU_PASS_B = 5'd11;

   localparam logic [1:0] WB_MEM  = 2'd1;
   localparam logic [1:0] WB_PC4  = 2'd2;
   localparam logic [1:0] PC_ALU  = 2'd1;
   localparam logic [1:0] PC_IMM  = 2'd2;

   logic [31:0]      instr_mem [DEPTH];
   logic [31:0]      pc_mem    [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count_q;

   logic             push;
   logic             pop;
   logic             head_valid;
   logic [31:0]      head_instr;
   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic [6:0]       funct7;

   logic             dec_reg_write;
   logic             dec_mem_read;
   logic             dec_mem_write;
   logic             dec_branch;
   logic             dec_jump;
   logic             dec_alu_src;
   logic             dec_illegal;
   logic [4:0]       dec_alu_op;
   logic [1:0]       dec_wb_sel;
   logic [1:0]       dec_pc_sel;

   // Handshake qualifiers. rst and flush both close the push side so that a
   // beat offered during those cycles is never accepted. Pop does not need
   // the same gating because the state update ignores it under rst/flush.
   assign head_valid = (count_q != '0);
   assign push       = q.in_valid && q.in_ready;
   assign pop        = head_valid && q.out_ready;

   assign q.in_ready  = !rst && !q.flush && (count_q < FULL_CNT);
   assign q.out_valid = head_valid;
   assign q.count     = count_q;

   assign head_instr  = instr_mem[rd_ptr];
   assign q.out_instr = head_instr;
   assign q.out_pc    = pc_mem[rd_ptr];

   // Pointer and occupancy bookkeeping. Pointers are exactly log2(DEPTH)
   // bits wide, so incrementing them wraps modulo DEPTH for free.
   always_ff @(posedge clk) begin
      if (rst || q.flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Payload storage needs no reset: an entry is only ever read after it
   // was written, and push is already blocked during rst and flush.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= q.in_instr;
         pc_mem[wr_ptr]    <= q.in_pc;
      end
   end

   assign opcode = head_instr[6:0];
   assign funct3 = head_instr[14:12];
   assign funct7 = head_instr[31:25];

   // Head-entry decoder. Every field starts at the NOP value and each opcode
   // only raises what it needs; an empty queue forces the NOP at the end so
   // stale storage never leaks onto the control outputs.
   always_comb begin
      dec_reg_write = 1'b0;
      dec_mem_read  = 1'b0;
      dec_mem_write = 1'b0;
      dec_branch    = 1'b0;
      dec_jump      = 1'b0;
      dec_alu_src   = 1'b0;
      dec_illegal   = 1'b0;
      dec_alu_op    = ALU_ADD;
      dec_wb_sel    = 2'd0;
      dec_pc_sel    = 2'd0;

      case (opcode)
         OPC_LUI: begin
            dec_reg_write = 1'b1;
            dec_alu_src   = 1'b1;
            dec_alu_op    = ALU_PASS_B;
         end
         OPC_AUIPC: begin
            dec_reg_write = 1'b1;
            dec_alu_src   = 1'b1;
         end
         OPC_JAL: begin
            dec_reg_write = 1'b1;
            dec_jump      = 1'b1;
            dec_wb_sel    = WB_PC4;
            dec_pc_sel    = PC_IMM;
         end
         OPC_JALR: begin
            dec_reg_write = 1'b1;
            dec_jump      = 1'b1;
            dec_alu_src   = 1'b1;
            dec_wb_sel    = WB_PC4;
            dec_pc_sel    = PC_ALU;
         end
         OPC_BRANCH: begin
            case (funct3)
               3'b000, 3'b001: begin
                  dec_branch = 1'b1;
                  dec_alu_op = ALU_SUB;
               end
               3'b100, 3'b101: begin
                  dec_branch = 1'b1;
                  dec_alu_op = ALU_SLT;
               end
               3'b110, 3'b111: begin
                  dec_branch = 1'b1;
                  dec_alu_op = ALU_SLTU;
               end
               default: dec_illegal = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            dec_reg_write = 1'b1;
            dec_mem_read  = 1'b1;
            dec_alu_src   = 1'b1;
            dec_wb_sel    = WB_MEM;
         end
         OPC_STORE: begin
            dec_mem_write = 1'b1;
            dec_alu_src   = 1'b1;
         end
         OPC_OP_IMM: begin
            dec_reg_write = 1'b1;
            dec_alu_src   = 1'b1;
            case (funct3)
               3'b000: dec_alu_op = ALU_ADD;
               3'b001: dec_alu_op = ALU_SLL;
               3'b010: dec_alu_op = ALU_SLT;
               3'b011: dec_alu_op = ALU_SLTU;
               3'b100: dec_alu_op = ALU_XOR;
               3'b101: dec_alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
               3'b110: dec_alu_op = ALU_OR;
               3'b111: dec_alu_op = ALU_AND;
            endcase
         end
         OPC_OP: begin
            if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
               dec_reg_write = 1'b1;
               case (funct3)
                  3'b000: dec_alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
                  3'b001: dec_alu_op = ALU_SLL;
                  3'b010: dec_alu_op = ALU_SLT;
                  3'b011: dec_alu_op = ALU_SLTU;
                  3'b100: dec_alu_op = ALU_XOR;
                  3'b101: dec_alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                  3'b110: dec_alu_op = ALU_OR;
                  3'b111: dec_alu_op = ALU_AND;
               endcase
            end else if (funct7 == 7'b0000001 && ENABLE_M != 0) begin
               // MUL..REMU occupy the upper half of the alu_op space
               dec_reg_write = 1'b1;
               dec_alu_op    = {2'b10, funct3};
            end else begin
               dec_illegal = 1'b1;
            end
         end
         OPC_MISC_MEM: begin
         end
         OPC_SYSTEM: begin
            // funct3==0 is ECALL/EBREAK, handled as a NOP here
            if (funct3 != 3'b000) begin
               if (ENABLE_CSR != 0) begin
                  dec_reg_write = 1'b1;
                  dec_alu_src   = 1'b1;
                  dec_alu_op    = ALU_PASS_B;
               end else begin
                  dec_illegal = 1'b1;
               end
            end
         end
         default: dec_illegal = 1'b1;
      endcase

      if (!head_valid) begin
         dec_reg_write = 1'b0;
         dec_mem_read  = 1'b0;
         dec_mem_write = 1'b0;
         dec_branch    = 1'b0;
         dec_jump      = 1'b0;
         dec_alu_src   = 1'b0;
         dec_illegal   = 1'b0;
         dec_alu_op    = ALU_ADD;
         dec_wb_sel    = 2'd0;
         dec_pc_sel    = 2'd0;
      end
   end

   assign q.reg_write = dec_reg_write;
   assign q.mem_read  = dec_mem_read;
   assign q.mem_write = dec_mem_write;
   assign q.branch    = dec_branch;
   assign q.jump      = dec_jump;
   assign q.alu_src   = dec_alu_src;
   assign q.illegal   = dec_illegal;
   assign q.alu_op    = dec_alu_op;
   assign q.wb_sel    = dec_wb_sel;
   assign q.pc_sel    = dec_pc_sel;
endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, >=2).
REQ-002 SHALL have parameter ENABLE_M, default 1, meaning RV32M ops decoded (0: treated as illegal).
REQ-003 SHALL have parameter ENABLE_CSR, default 1, meaning SYSTEM funct3!=0 decoded as CSR write-back (0: illegal).
REQ-004 SHALL have port clk  input  1  rising-edge clock; the block uses one clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port flush  input  1  discard all queued entries.
REQ-007 SHALL have ports in_valid input 1, in_ready output 1, in_instr input 32, in_pc input 32: fetch-side push handshake.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1, out_instr output 32, out_pc output 32: issue-side pop handshake.
REQ-009 SHALL have decoded outputs reg_write, mem_read, mem_write, branch, jump, alu_src, illegal (each output 1), alu_op output 5, wb_sel output 2, pc_sel output 2, all describing the head entry.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-011 SHALL store entries in a circular buffer with read/write pointers wrapping modulo DEPTH.
REQ-012 SHALL assert in_ready = (count < DEPTH) and flush==0; push occurs when in_valid && in_ready.
REQ-013 SHALL assert out_valid = (count != 0); pop occurs when out_valid && out_ready.
REQ-014 SHALL have latency one cycle: an entry pushed at edge N is visible on out_* after edge N; no combinational in->out bypass.
REQ-015 SHALL on simultaneous push and pop keep count unchanged and advance both pointers (legal when full: no, in_ready=0; legal when empty: no, out_valid=0).
REQ-016 SHALL keep out_instr, out_pc and decoded outputs stable while out_valid && !out_ready.
REQ-017 SHALL on flush set count=0 and both pointers=0 at the next edge; a push or pop in the flush cycle is ignored.
REQ-018 SHALL decode the head entry combinationally: opcode=instr[6:0], funct3=instr[14:12], funct7=instr[31:25].
REQ-019 SHALL use alu_op codes ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, PASS_A 10, PASS_B 11, and 16+funct3 for MUL..REMU.
REQ-020 SHALL use wb_sel ALU 0, MEM 1, PC4 2; pc_sel PLUS4 0, ALU 1, IMM 2.
REQ-021 SHALL decode LUI: reg_write, alu_src, PASS_B; AUIPC: reg_write, alu_src, ADD; JAL: reg_write, jump, wb PC4, pc IMM; JALR: reg_write, jump, alu_src, ADD, wb PC4, pc ALU.
REQ-022 SHALL decode BRANCH: branch=1; funct3 000/001 SUB, 100/101 SLT, 110/111 SLTU; funct3 010/011 illegal.
REQ-023 SHALL decode LOAD: reg_write, mem_read, alu_src, ADD, wb MEM; STORE: mem_write, alu_src, ADD.
REQ-024 SHALL decode OP-IMM by funct3 (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI/SRAI by funct7[5]) with reg_write, alu_src.
REQ-025 SHALL decode OP: funct7=0000000/0100000 as base ALU ops (SUB/SRA only for funct7[5] with funct3 000/101); funct7=0000001 as 16+funct3 when ENABLE_M=1; any other funct7 illegal.
REQ-026 SHALL decode FENCE and ECALL/EBREAK (SYSTEM funct3=000) as NOPs, illegal=0.
REQ-027 SHALL decode SYSTEM funct3!=000 as reg_write, alu_src, PASS_B when ENABLE_CSR=1, else illegal.
REQ-028 SHALL for illegal or unknown opcode drive illegal=1 with reg_write, mem_read, mem_write, branch, jump all 0.
REQ-029 SHALL drive all decoded outputs to 0 (alu_op=ADD, NOP) whenever out_valid=0.

Reset
REQ-030 SHALL on rst set count=0, pointers=0, giving out_valid=0, in_ready=0 during the rst cycle and 1 after, decoded outputs 0.
REQ-031 SHALL give rst priority over flush, push and pop; rst mid-stream discards all entries.

Verification
REQ-032 Push 0x00500093 (ADDI) into empty queue -> next cycle out_valid=1, reg_write=1, alu_src=1, alu_op=0, count=1.
REQ-033 Push DEPTH=4 entries with out_ready=0 -> count=4, in_ready=0; fifth push ignored; pop all four in order with matching out_pc.
REQ-034 Continuous push+pop for 10 cycles across pointer wrap -> count constant, in-order data, no loss.
REQ-035 Push 0x02B50533 (MUL) with ENABLE_M=1 -> alu_op=16, illegal=0; with ENABLE_M=0 -> illegal=1, reg_write=0.
REQ-036 Fill 3 entries, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, pushed entry dropped.
REQ-037 Push 0xFFFFFFFF -> illegal=1, all write/branch/jump controls 0; rst mid-stream with count=2 -> count=0 next cycle.
